// File: rtl/demux_sched_ctrl.sv
// Select/handshake controller for a 1-to-2 demux: routes a valid/ready stream into
// one-entry output registers for channels B and C, in manual or round-robin mode.
module demux_sched_ctrl #(
    parameter int DATA_W    = 2,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              sel_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] outB_data,
    output logic              outB_valid,
    input  logic              outB_ready,
    output logic [DATA_W-1:0] outC_data,
    output logic              outC_valid,
    input  logic              outC_ready,
    output logic              cur_sel,
    output logic [7:0]        burst_cnt
);

    typedef enum logic {
        ROUTE  = 1'b0,
        SWITCH = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_LEN);

    state_t            state_q, state_d;
    logic              cur_sel_q, cur_sel_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              b_valid_q, b_valid_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              c_valid_q, c_valid_d;
    logic [DATA_W-1:0] c_data_q, c_data_d;

    logic cur_valid;
    logic cur_ready;
    logic switch_cond;
    logic route_rdy;
    logic accept;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        cur_valid   = cur_sel_q ? c_valid_q : b_valid_q;
        cur_ready   = cur_sel_q ? outC_ready : outB_ready;
        switch_cond = mode ? (burst_cnt_q == BURST_LIM) : (sel_req != cur_sel_q);
    end

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        burst_cnt_d = mode ? burst_cnt_q : 8'd0;
        route_rdy   = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ROUTE: begin
                if (switch_cond) begin
                    state_d = SWITCH;
                end else begin
                    route_rdy = !cur_valid || cur_ready;
                    accept    = in_valid && route_rdy && !rst;
                    if (accept && mode) begin
                        burst_cnt_d = sat_inc(burst_cnt_q);
                    end
                end
            end
            SWITCH: begin
                // Flip only once the old destination holds nothing still unconsumed.
                if (!cur_valid || cur_ready) begin
                    cur_sel_d   = ~cur_sel_q;
                    burst_cnt_d = 8'd0;
                    state_d     = ROUTE;
                end
            end
            default: begin
                state_d = ROUTE;
            end
        endcase

        in_ready = route_rdy && !rst;
    end

    always_comb begin
        b_valid_d = b_valid_q && !outB_ready;
        b_data_d  = b_data_q;
        c_valid_d = c_valid_q && !outC_ready;
        c_data_d  = c_data_q;
        if (accept && !cur_sel_q) begin
            b_valid_d = 1'b1;
            b_data_d  = in_data;
        end
        if (accept && cur_sel_q) begin
            c_valid_d = 1'b1;
            c_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ROUTE;
            cur_sel_q   <= 1'b0;
            burst_cnt_q <= 8'd0;
            b_valid_q   <= 1'b0;
            b_data_q    <= '0;
            c_valid_q   <= 1'b0;
            c_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            burst_cnt_q <= burst_cnt_d;
            b_valid_q   <= b_valid_d;
            b_data_q    <= b_data_d;
            c_valid_q   <= c_valid_d;
            c_data_q    <= c_data_d;
        end
    end

    assign outB_data  = b_data_q;
    assign outB_valid = b_valid_q;
    assign outC_data  = c_data_q;
    assign outC_valid = c_valid_q;
    assign cur_sel    = cur_sel_q;
    assign burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_demux_sched_ctrl.sv
// Directed bench for demux_sched_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_demux_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       sel_req;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] outB_data;
    logic       outB_valid;
    logic       outB_ready;
    logic [1:0] outC_data;
    logic       outC_valid;
    logic       outC_ready;
    logic       cur_sel;
    logic [7:0] burst_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_sched_ctrl #(.DATA_W(2), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel_req   (sel_req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outB_data (outB_data),
        .outB_valid(outB_valid),
        .outB_ready(outB_ready),
        .outC_data (outC_data),
        .outC_valid(outC_valid),
        .outC_ready(outC_ready),
        .cur_sel   (cur_sel),
        .burst_cnt (burst_cnt)
    );

    typedef struct {
        logic        rst;
        logic        mode;
        logic        sel;
        logic [1:0]  d;
        logic        v;
        logic        br;
        logic        cr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected packing: {in_ready, outB_valid, outB_data, outC_valid, outC_data, cur_sel, burst_cnt}
    task automatic add(input logic r, input logic m, input logic s, input logic [1:0] d,
                       input logic v, input logic br, input logic cr,
                       input logic ir, input logic bv, input logic [1:0] bd,
                       input logic cv, input logic [1:0] cd, input logic cs, input logic [7:0] bc);
        vec_t x;
        x.rst = r; x.mode = m; x.sel = s; x.d = d; x.v = v; x.br = br; x.cr = cr;
        x.exp = {ir, bv, bd, cv, cd, cs, bc};
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; sel_req = 1'b0;
        outB_ready = 1'b1; outC_ready = 1'b1; in_data = 2'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] act;
        logic [1:0]  qb[$];
        logic [1:0]  qc[$];
        int idx, nb, nc, low, gaps;
        logic prev_sel;

        rst = 1'b1; mode = 1'b0; sel_req = 1'b0; in_data = 2'd0; in_valid = 1'b0;
        outB_ready = 1'b1; outC_ready = 1'b1;

        //   rst m s d v bR cR   ir bV bD cV cD cs bc
        add(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 1,   1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 2, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 1, 1, 1,   1, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1,   1, 1, 3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1,   1, 0, 3, 0, 0, 0, 0);
        // Item 2 parked on B under stall, then a manual switch request
        add(0, 0, 0, 2, 1, 0, 1,   1, 0, 3, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 0, 1,   0, 1, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 0, 1,   0, 1, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 0, 1,   0, 1, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 1, 1,   0, 1, 2, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 1, 1,   1, 0, 2, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 1,   1, 0, 2, 1, 3, 1, 0);
        // Backpressure on C holding item 2 for five cycles
        add(0, 0, 1, 2, 1, 1, 1,   1, 0, 2, 0, 3, 1, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 1, 1, 1, 0,   0, 0, 2, 1, 2, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1,   1, 0, 2, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 1, 1,   1, 0, 2, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 1, 1,   1, 0, 2, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; mode = vecs[i].mode; sel_req = vecs[i].sel;
            in_data = vecs[i].d; in_valid = vecs[i].v;
            outB_ready = vecs[i].br; outC_ready = vecs[i].cr;
            @(negedge clk);
            act = {in_ready, outB_valid, outB_data, outC_valid, outC_data, cur_sel, burst_cnt};
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec[%0d]: got %b expected %b", i, act, vecs[i].exp);
            end
            next_cycle();
        end

        // Round-robin: 12 items, bursts of 4 alternating B, C, B
        do_reset();
        mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 4 || k >= 8) qb.push_back(2'(k % 4));
            else qc.push_back(2'(k % 4));
        end
        idx = 0; nb = 0; nc = 0; low = 0; gaps = 0; prev_sel = 1'b0;
        for (int cyc = 0; cyc < 100 && !(idx == 12 && nb == 8 && nc == 4); cyc++) begin
            in_valid = (idx < 12);
            in_data  = 2'(idx % 4);
            @(negedge clk);
            if (outB_valid) begin
                if (qb.size() > 0) check("rr_b_order", int'(outB_data), int'(qb.pop_front()));
                else check("rr_b_extra", 1, 0);
                nb++;
            end
            if (outC_valid) begin
                if (qc.size() > 0) check("rr_c_order", int'(outC_data), int'(qc.pop_front()));
                else check("rr_c_extra", 1, 0);
                nc++;
            end
            if (idx >= 1 && idx < 12) begin
                if (!in_ready) low++;
                else if (low > 0) begin
                    // Decision cycle in ROUTE plus the single drain cycle in SWITCH
                    check("rr_gap_len", low, 2);
                    low = 0;
                    gaps++;
                end
            end
            if (cur_sel != prev_sel) begin
                check("rr_cnt_clear", int'(burst_cnt), 0);
                prev_sel = cur_sel;
            end
            if (burst_cnt > 8'd4) check("rr_cnt_max", int'(burst_cnt), 4);
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        check("rr_accepted", idx, 12);
        check("rr_b_count", nb, 8);
        check("rr_c_count", nc, 4);
        check("rr_gaps", gaps, 2);
        in_valid = 1'b0;

        // Mode 1->0 clears the counter; 0->1 restarts from 0
        do_reset();
        mode = 1'b1; in_valid = 1'b1; in_data = 2'd1;
        next_cycle();
        next_cycle();
        mode = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("mode_cnt_before", int'(burst_cnt), 2);
        next_cycle();
        @(negedge clk);
        check("mode_cnt_cleared", int'(burst_cnt), 0);
        mode = 1'b1; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("mode_cnt_restart", int'(burst_cnt), 1);
        next_cycle();

        // Reset while B holds an item and three items counted
        do_reset();
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 2'(k + 1);
            @(negedge clk);
            check("mr_accept", int'(in_ready), 1);
            next_cycle();
        end
        rst = 1'b1; in_valid = 1'b0; outB_ready = 1'b0;
        @(negedge clk);
        check("mr_pre_bvalid", int'(outB_valid), 1);
        check("mr_pre_cnt", int'(burst_cnt), 3);
        next_cycle();
        rst = 1'b0; outB_ready = 1'b1;
        @(negedge clk);
        check("mr_bvalid", int'(outB_valid), 0);
        check("mr_bdata", int'(outB_data), 0);
        check("mr_cvalid", int'(outC_valid), 0);
        check("mr_cdata", int'(outC_data), 0);
        check("mr_sel", int'(cur_sel), 0);
        check("mr_cnt", int'(burst_cnt), 0);
        check("mr_ready", int'(in_ready), 1);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            check("mr_no_replay", int'(outB_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
